// File: rtl/rf_pkg.sv
// Shared types and helpers for the register-file port arbiter: FSM encoding,
// requester indices and round-robin ring arithmetic.
package rf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_WR0 = 2'd0;
    localparam req_idx_t REQ_WR1 = 2'd1;
    localparam req_idx_t REQ_RD  = 2'd2;

    // Successor on the ring WR0 -> WR1 -> RD -> WR0.
    function automatic req_idx_t rr_next(input req_idx_t idx);
        return (idx == REQ_RD) ? REQ_WR0 : req_idx_t'(idx + 2'd1);
    endfunction

    // Position of 'to' in the search order that starts at 'from' (0 = searched first).
    function automatic logic [1:0] rr_dist(input req_idx_t from, input req_idx_t to);
        return (to >= from) ? 2'(to - from) : 2'(to + 2'd3 - from);
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin: first requester found walking the ring
// from ptr_i wins; one-hot grant plus its index.
module rr_arbiter3
    import rf_pkg::*;
(
    input  logic [2:0] req_i,
    input  req_idx_t   ptr_i,
    output logic [2:0] gnt_o,
    output req_idx_t   gnt_idx_o,
    output logic       gnt_any_o
);

    req_idx_t idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = ptr_i;
        gnt_any_o = 1'b0;
        idx       = ptr_i;
        for (int k = 0; k < 3; k++) begin
            if (!gnt_any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                gnt_any_o  = 1'b1;
            end
            idx = rr_next(idx);
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares a single-port register file between two writers and one dual-address
// reader, and holds the register file in clear for a few cycles after reset.
module regfile_port_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CLR_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              clear_n_i,
    input  logic              wr0_valid_i,
    input  logic [ADDR_W-1:0] wr0_addr_i,
    input  logic [DATA_W-1:0] wr0_data_i,
    output logic              wr0_ready_o,
    input  logic              wr1_valid_i,
    input  logic [ADDR_W-1:0] wr1_addr_i,
    input  logic [DATA_W-1:0] wr1_data_i,
    output logic              wr1_ready_o,
    input  logic              rd_valid_i,
    input  logic [ADDR_W-1:0] rd_addrA_i,
    input  logic [ADDR_W-1:0] rd_addrB_i,
    output logic              rd_ready_o,
    output logic              rf_clear_o,
    output logic              rf_wr_o,
    output logic              rf_rd_o,
    output logic [ADDR_W-1:0] rf_write_reg_o,
    output logic [DATA_W-1:0] rf_data_o,
    output logic [ADDR_W-1:0] rf_read_regA_o,
    output logic [ADDR_W-1:0] rf_read_regB_o,
    output logic              busy_o
);

    localparam int              CNT_W    = $clog2(CLR_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLR_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_idx_t          ptr_q, ptr_d;

    logic              rf_wr_q, rf_wr_d;
    logic              rf_rd_q, rf_rd_d;
    logic [ADDR_W-1:0] rf_write_reg_q, rf_write_reg_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [ADDR_W-1:0] rf_read_regA_q, rf_read_regA_d;
    logic [ADDR_W-1:0] rf_read_regB_q, rf_read_regB_d;

    logic              hazard;
    logic              rd_blocked;
    logic [2:0]        req;
    logic [2:0]        arb_gnt;
    req_idx_t          arb_idx;
    logic              arb_any;
    logic              gnt_en;
    logic [2:0]        grant;

    // A read touching the register being written this cycle would see stale data.
    assign hazard = rf_wr_q && ((rf_write_reg_q == rd_addrA_i) || (rf_write_reg_q == rd_addrB_i));
    assign rd_blocked = rd_valid_i && hazard;
    assign req = {rd_valid_i && !hazard, wr1_valid_i, wr0_valid_i};

    rr_arbiter3 u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .gnt_any_o (arb_any)
    );

    assign gnt_en = (state_q == ST_RUN);
    assign grant  = gnt_en ? arb_gnt : 3'b000;

    assign wr0_ready_o = grant[REQ_WR0];
    assign wr1_ready_o = grant[REQ_WR1];
    assign rd_ready_o  = grant[REQ_RD];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // A hazard-blocked read keeps its turn: the pointer never jumps over it.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_en && arb_any) begin
            if (rd_blocked && (rr_dist(ptr_q, REQ_RD) < rr_dist(ptr_q, arb_idx))) begin
                ptr_d = REQ_RD;
            end else begin
                ptr_d = rr_next(arb_idx);
            end
        end
    end

    always_comb begin
        rf_wr_d        = grant[REQ_WR0] | grant[REQ_WR1];
        rf_rd_d        = grant[REQ_RD];
        rf_write_reg_d = rf_write_reg_q;
        rf_data_d      = rf_data_q;
        rf_read_regA_d = rf_read_regA_q;
        rf_read_regB_d = rf_read_regB_q;
        if (grant[REQ_WR0]) begin
            rf_write_reg_d = wr0_addr_i;
            rf_data_d      = wr0_data_i;
        end else if (grant[REQ_WR1]) begin
            rf_write_reg_d = wr1_addr_i;
            rf_data_d      = wr1_data_i;
        end
        if (grant[REQ_RD]) begin
            rf_read_regA_d = rd_addrA_i;
            rf_read_regB_d = rd_addrB_i;
        end
    end

    always_ff @(posedge clk_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            state_q        <= ST_INIT;
            cnt_q          <= '0;
            ptr_q          <= REQ_WR0;
            rf_wr_q        <= 1'b0;
            rf_rd_q        <= 1'b0;
            rf_write_reg_q <= '0;
            rf_data_q      <= '0;
            rf_read_regA_q <= '0;
            rf_read_regB_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ptr_q          <= ptr_d;
            rf_wr_q        <= rf_wr_d;
            rf_rd_q        <= rf_rd_d;
            rf_write_reg_q <= rf_write_reg_d;
            rf_data_q      <= rf_data_d;
            rf_read_regA_q <= rf_read_regA_d;
            rf_read_regB_q <= rf_read_regB_d;
        end
    end

    assign rf_clear_o     = (state_q == ST_INIT);
    assign busy_o         = (state_q == ST_INIT);
    assign rf_wr_o        = rf_wr_q;
    assign rf_rd_o        = rf_rd_q;
    assign rf_write_reg_o = rf_write_reg_q;
    assign rf_data_o      = rf_data_q;
    assign rf_read_regA_o = rf_read_regA_q;
    assign rf_read_regB_o = rf_read_regB_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed expected register-file
// transactions, a negedge monitor pops and compares them.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        wr0_valid = 1'b0, wr1_valid = 1'b0, rd_valid = 1'b0;
    logic [4:0]  wr0_addr = '0, wr1_addr = '0, rd_addrA = '0, rd_addrB = '0;
    logic [31:0] wr0_data = '0, wr1_data = '0;
    logic        wr0_ready, wr1_ready, rd_ready;
    logic        rf_clear, rf_wr, rf_rd, busy;
    logic [4:0]  rf_write_reg, rf_read_regA, rf_read_regB;
    logic [31:0] rf_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_rd;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] da;
        logic [31:0] db;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    logic [31:0] mem [32];

    always #5 clk = ~clk;

    regfile_port_arbiter dut (
        .clk_i          (clk),
        .clear_n_i      (clear_n),
        .wr0_valid_i    (wr0_valid),
        .wr0_addr_i     (wr0_addr),
        .wr0_data_i     (wr0_data),
        .wr0_ready_o    (wr0_ready),
        .wr1_valid_i    (wr1_valid),
        .wr1_addr_i     (wr1_addr),
        .wr1_data_i     (wr1_data),
        .wr1_ready_o    (wr1_ready),
        .rd_valid_i     (rd_valid),
        .rd_addrA_i     (rd_addrA),
        .rd_addrB_i     (rd_addrB),
        .rd_ready_o     (rd_ready),
        .rf_clear_o     (rf_clear),
        .rf_wr_o        (rf_wr),
        .rf_rd_o        (rf_rd),
        .rf_write_reg_o (rf_write_reg),
        .rf_data_o      (rf_data),
        .rf_read_regA_o (rf_read_regA),
        .rf_read_regB_o (rf_read_regB),
        .busy_o         (busy)
    );

    // Behavioural register file: commits at the end of the rf_wr cycle, reads combinationally.
    always @(posedge clk) begin
        if (rf_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (rf_wr) begin
            mem[rf_write_reg] <= rf_data;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (clear_n && (rf_wr || rf_rd)) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_txn: got wr=%0b rd=%0b wreg=%0h data=%0h expected none",
                         rf_wr, rf_rd, rf_write_reg, rf_data);
            end else begin
                mon_e = sbq.pop_front();
                if (!mon_e.is_rd) begin
                    if (rf_wr && !rf_rd && rf_write_reg == mon_e.a && rf_data == mon_e.da)
                        $display("txn write reg=%0h data=%h ok", rf_write_reg, rf_data);
                    else begin
                        errors++;
                        $display("FAIL write_txn: got wr=%0b rd=%0b reg=%0h data=%h expected reg=%0h data=%h",
                                 rf_wr, rf_rd, rf_write_reg, rf_data, mon_e.a, mon_e.da);
                    end
                end else begin
                    if (rf_rd && !rf_wr && rf_read_regA == mon_e.a && rf_read_regB == mon_e.b &&
                        mem[rf_read_regA] == mon_e.da && mem[rf_read_regB] == mon_e.db)
                        $display("txn read A=%0h B=%0h readA=%h readB=%h ok",
                                 rf_read_regA, rf_read_regB, mem[rf_read_regA], mem[rf_read_regB]);
                    else begin
                        errors++;
                        $display("FAIL read_txn: got wr=%0b rd=%0b A=%0h B=%0h readA=%h readB=%h expected A=%0h B=%0h readA=%h readB=%h",
                                 rf_wr, rf_rd, rf_read_regA, rf_read_regB, mem[rf_read_regA],
                                 mem[rf_read_regB], mon_e.a, mon_e.b, mon_e.da, mon_e.db);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [2:0] gnt, input logic [31:0] eda, input logic [31:0] edb);
        exp_t e;
        if (gnt[0]) begin
            e = '{is_rd: 1'b0, a: wr0_addr, b: 5'd0, da: wr0_data, db: 32'd0};
            sbq.push_back(e);
        end else if (gnt[1]) begin
            e = '{is_rd: 1'b0, a: wr1_addr, b: 5'd0, da: wr1_data, db: 32'd0};
            sbq.push_back(e);
        end else if (gnt[2]) begin
            e = '{is_rd: 1'b1, a: rd_addrA, b: rd_addrB, da: eda, db: edb};
            sbq.push_back(e);
        end
    endtask

    // One RUN cycle: drive requests (called at posedge+1), check grants at negedge.
    task automatic step(input logic [2:0] vld,
                        input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic [2:0] exp_gnt,
                        input logic [31:0] eda, input logic [31:0] edb);
        wr0_valid = vld[0]; wr0_addr = a0; wr0_data = d0;
        wr1_valid = vld[1]; wr1_addr = a1; wr1_data = d1;
        rd_valid  = vld[2]; rd_addrA = ra; rd_addrB = rb;
        @(negedge clk);
        chk("grant", {rd_ready, wr1_ready, wr0_ready}, exp_gnt);
        push_exp(exp_gnt, eda, edb);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 5'd0, 3'b000, 32'd0, 32'd0);
    endtask

    // Counts INIT cycles after release; returns at the negedge of the first RUN cycle.
    task automatic wait_init(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!rf_clear) break;
            n++;
            chk("init_ready", {rd_ready, wr1_ready, wr0_ready}, 3'b000);
            chk("init_busy", busy, 1'b1);
        end
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset with a write request pending; nothing may be granted during INIT.
        wr0_valid = 1'b1; wr0_addr = 5'h1f; wr0_data = 32'hdeadbeef;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_clear", rf_clear, 1'b1);
        chk("rst_busy", busy, 1'b1);
        chk("rst_wr_rd", {rf_wr, rf_rd}, 2'b00);
        chk("rst_ready", {rd_ready, wr1_ready, wr0_ready}, 3'b000);
        chk("rst_regs", {rf_write_reg, rf_data, rf_read_regA, rf_read_regB}, '0);
        repeat (2) @(posedge clk);
        #1 clear_n = 1'b1;
        wait_init(n);
        chk("init_len", n, 4);
        chk("run_busy", busy, 1'b0);
        chk("first_grant", {rd_ready, wr1_ready, wr0_ready}, 3'b001);
        push_exp(3'b001, 32'd0, 32'd0);
        @(posedge clk); #1;

        // Lone WR0 to register 0; pointer then WR1.
        step(3'b001, 5'h00, 32'h123abc01, 5'd0, 32'd0, 5'd0, 5'd0, 3'b001, 32'd0, 32'd0);
        idle();
        step(3'b010, 5'd0, 32'd0, 5'h03, 32'h33333333, 5'd0, 5'd0, 3'b010, 32'd0, 32'd0);
        idle();
        step(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'h00, 5'h03, 3'b100, 32'h123abc01, 32'h33333333);
        idle();

        // All three continuously valid from pointer WR0.
        step(3'b111, 5'h08, 32'h80808080, 5'h09, 32'h90909090, 5'h00, 5'h03, 3'b001, 32'h123abc01, 32'h33333333);
        step(3'b111, 5'h08, 32'h80808080, 5'h09, 32'h90909090, 5'h00, 5'h03, 3'b010, 32'h123abc01, 32'h33333333);
        step(3'b111, 5'h08, 32'h80808080, 5'h09, 32'h90909090, 5'h00, 5'h03, 3'b100, 32'h123abc01, 32'h33333333);
        step(3'b111, 5'h08, 32'h80808080, 5'h09, 32'h90909090, 5'h00, 5'h03, 3'b001, 32'h123abc01, 32'h33333333);
        idle();

        // RAW hazard: read of register 5 stalls one cycle behind its write.
        step(3'b010, 5'd0, 32'd0, 5'h05, 32'haaaabcaa, 5'd0, 5'd0, 3'b010, 32'd0, 32'd0);
        step(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'h00, 5'h05, 3'b000, 32'd0, 32'd0);
        step(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'h00, 5'h05, 3'b100, 32'h123abc01, 32'haaaabcaa);
        idle();

        // Blocked read keeps its turn: pointer stays at RD while WR0 is served.
        step(3'b010, 5'd0, 32'd0, 5'h06, 32'h66666666, 5'd0, 5'd0, 3'b010, 32'd0, 32'd0);
        step(3'b101, 5'h07, 32'h77777777, 5'd0, 32'd0, 5'h06, 5'h01, 3'b001, 32'd0, 32'd0);
        step(3'b110, 5'd0, 32'd0, 5'h0a, 32'haaaa0000, 5'h06, 5'h01, 3'b100, 32'h66666666, 32'h00000000);
        step(3'b010, 5'd0, 32'd0, 5'h0a, 32'haaaa0000, 5'd0, 5'd0, 3'b010, 32'd0, 32'd0);
        idle();

        // Both writers to the same register: served one after the other, later data sticks.
        step(3'b011, 5'h0c, 32'h0c0c0c00, 5'h0c, 32'h0c0c0c01, 5'd0, 5'd0, 3'b001, 32'd0, 32'd0);
        step(3'b010, 5'd0, 32'd0, 5'h0c, 32'h0c0c0c01, 5'd0, 5'd0, 3'b010, 32'd0, 32'd0);
        idle();
        step(3'b100, 5'd0, 32'd0, 5'd0, 32'd0, 5'h0c, 5'h0c, 3'b100, 32'h0c0c0c01, 32'h0c0c0c01);
        idle();

        // Ten idle cycles: no pulses, address/data outputs hold.
        for (int i = 0; i < 10; i++) begin
            idle();
            chk("idle_pulses", {rf_wr, rf_rd}, 2'b00);
            chk("idle_hold", {rf_write_reg, rf_data, rf_read_regA, rf_read_regB},
                {5'h0c, 32'h0c0c0c01, 5'h0c, 5'h0c});
        end

        // Reset while a write pulse is on the outputs; the write is dropped.
        wr0_valid = 1'b1; wr0_addr = 5'h0e; wr0_data = 32'heeeeeeee;
        @(negedge clk);
        chk("pre_rst_grant", {rd_ready, wr1_ready, wr0_ready}, 3'b001);
        @(posedge clk); #1;
        wr0_valid = 1'b0;
        chk("pre_rst_wr", rf_wr, 1'b1);
        clear_n = 1'b0;
        #1;
        chk("mid_rst_wr", rf_wr, 1'b0);
        chk("mid_rst_clear", {rf_clear, busy}, 2'b11);
        wr0_valid = 1'b1; wr0_addr = 5'h0f; wr0_data = 32'h5555aaaa;
        wr1_valid = 1'b1; wr1_addr = 5'h10; wr1_data = 32'h10101010;
        rd_valid  = 1'b1; rd_addrA = 5'h00; rd_addrB = 5'h00;
        repeat (3) @(posedge clk);
        #1 clear_n = 1'b1;
        wait_init(n);
        chk("init_len2", n, 4);
        chk("ptr_after_rst", {rd_ready, wr1_ready, wr0_ready}, 3'b001);
        push_exp(3'b001, 32'd0, 32'd0);
        @(posedge clk); #1;
        idle();
        idle();
        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
